// File: rtl/ftb_update_ctrl_if.sv
// Port bundle between the FTB training controller, its update source, the prediction
// lookup path and the shared single-port FTB SRAM.
interface ftb_update_ctrl_if #(
  parameter int unsigned FTB_SETS      = 512,
  parameter int unsigned FTB_TAG_WIDTH = 20,
  parameter int unsigned INFO_W        = 16
);
  localparam int unsigned IDX_W   = $clog2(FTB_SETS);
  localparam int unsigned ENTRY_W = FTB_TAG_WIDTH + 1 + INFO_W;

  logic                     i_pred_req;
  logic [IDX_W-1:0]         i_pred_idx;
  logic                     o_pred_gnt;

  logic                     i_upd_vld;
  logic                     o_upd_rdy;
  logic [IDX_W-1:0]         i_upd_idx;
  logic [FTB_TAG_WIDTH-1:0] i_upd_tag;
  logic [INFO_W-1:0]        i_upd_info;
  logic                     i_upd_taken;

  logic                     o_sram_en;
  logic                     o_sram_we;
  logic [IDX_W-1:0]         o_sram_addr;
  logic [ENTRY_W-1:0]       o_sram_wdata;
  logic [ENTRY_W-1:0]       i_sram_rdata;

  logic                     o_busy;

  modport slave (
    input  i_pred_req, i_pred_idx, i_upd_vld, i_upd_idx, i_upd_tag, i_upd_info, i_upd_taken,
    input  i_sram_rdata,
    output o_pred_gnt, o_upd_rdy, o_sram_en, o_sram_we, o_sram_addr, o_sram_wdata, o_busy
  );

  modport master (
    output i_pred_req, i_pred_idx, i_upd_vld, i_upd_idx, i_upd_tag, i_upd_info, i_upd_taken,
    output i_sram_rdata,
    input  o_pred_gnt, o_upd_rdy, o_sram_en, o_sram_we, o_sram_addr, o_sram_wdata, o_busy
  );
endinterface

// File: rtl/ftb_update_ctrl.sv
// FTB training sequencer: queues updates and read-modify-writes FTB entries through a port
// shared with prediction. Define FTB_UPD_WRITE_FILTER_EN to skip writes that change nothing.
module ftb_update_ctrl #(
  parameter int unsigned FTB_SETS     = 512,
  parameter int unsigned QDEPTH       = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic              clk,
  input logic              rst,
  ftb_update_ctrl_if.slave bus
);
  localparam int unsigned IDX_W         = $clog2(FTB_SETS);
  localparam int unsigned FTB_TAG_WIDTH = 20;
  localparam int unsigned PTR_W         = $clog2(QDEPTH);
  localparam int unsigned CNT_W         = PTR_W + 1;
  localparam int unsigned STARVE_W      = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [1:0]  br_type;
    logic [11:0] target;
    logic [1:0]  ctr;
  } ftb_info_t;

  typedef struct packed {
    logic [FTB_TAG_WIDTH-1:0] tag;
    logic                     vld;
    ftb_info_t                info;
  } ftb_entry_t;

  typedef struct packed {
    logic [IDX_W-1:0]         idx;
    logic [FTB_TAG_WIDTH-1:0] tag;
    ftb_info_t                info;
    logic                     taken;
  } upd_t;

  typedef enum logic [1:0] {StIdle, StRd, StMod, StWr} state_e;

  localparam int unsigned INFO_W  = $bits(ftb_info_t);
  localparam int unsigned ENTRY_W = $bits(ftb_entry_t);

  state_e               state_q, state_d;
  upd_t                 q_mem [QDEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  upd_t                 work_q, work_d;
  ftb_entry_t           new_q, new_d;

  logic                     q_full, q_empty, push, pop;
  logic                     need_port, upd_wins, skip_wr;
  upd_t                     push_data;
  logic                     rd_vld, hit;
  logic [FTB_TAG_WIDTH-1:0] rd_tag;
  logic [1:0]               rd_ctr, sat_ctr;
  ftb_info_t                new_info;
  ftb_entry_t               new_entry;

  assign q_full    = (cnt_q == CNT_W'(QDEPTH));
  assign q_empty   = (cnt_q == '0);
  assign push      = bus.i_upd_vld && !q_full;
  assign pop       = (state_q == StIdle) && !q_empty;
  assign push_data = {bus.i_upd_idx, bus.i_upd_tag, bus.i_upd_info, bus.i_upd_taken};

  assign rd_tag = bus.i_sram_rdata[ENTRY_W-1 -: FTB_TAG_WIDTH];
  assign rd_vld = bus.i_sram_rdata[INFO_W];
  assign rd_ctr = bus.i_sram_rdata[1:0];

  // New entry keeps the update's info but takes the trained counter.
  always_comb begin
    hit = rd_vld && (rd_tag == work_q.tag);
    if (hit) begin
      if (work_q.taken) sat_ctr = (rd_ctr == 2'd3) ? 2'd3 : rd_ctr + 2'd1;
      else              sat_ctr = (rd_ctr == 2'd0) ? 2'd0 : rd_ctr - 2'd1;
    end else begin
      sat_ctr = work_q.taken ? 2'b10 : 2'b01;
    end
    new_info     = work_q.info;
    new_info.ctr = sat_ctr;
    new_entry    = '{tag: work_q.tag, vld: 1'b1, info: new_info};
  end

`ifdef FTB_UPD_WRITE_FILTER_EN
  assign skip_wr = (new_entry == bus.i_sram_rdata);
`else
  assign skip_wr = 1'b0;
`endif

  always_comb begin
    need_port = (state_q == StRd) || (state_q == StWr);
    upd_wins  = need_port && !(bus.i_pred_req && (starve_q < STARVE_W'(STARVE_LIMIT)));

    starve_d = starve_q;
    if (need_port) starve_d = upd_wins ? '0 : starve_q + 1'b1;

    state_d = state_q;
    work_d  = work_q;
    new_d   = new_q;
    unique case (state_q)
      StIdle: begin
        if (!q_empty) begin
          state_d = StRd;
          work_d  = q_mem[rd_ptr_q];
        end
      end
      StRd: if (upd_wins) state_d = StMod;
      StMod: begin
        new_d   = new_entry;
        state_d = skip_wr ? StIdle : StWr;
      end
      StWr: if (upd_wins) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Outputs are forced idle during reset so an in-flight write never reaches the array.
  always_comb begin
    bus.o_pred_gnt   = 1'b0;
    bus.o_sram_en    = 1'b0;
    bus.o_sram_we    = 1'b0;
    bus.o_sram_addr  = '0;
    bus.o_sram_wdata = new_q;
    if (!rst) begin
      if (upd_wins) begin
        bus.o_sram_en   = 1'b1;
        bus.o_sram_we   = (state_q == StWr);
        bus.o_sram_addr = work_q.idx;
      end else begin
        bus.o_pred_gnt  = bus.i_pred_req;
        bus.o_sram_en   = bus.i_pred_req;
        bus.o_sram_addr = bus.i_pred_idx;
      end
    end
  end

  assign bus.o_upd_rdy = !q_full;
  assign bus.o_busy    = !q_empty || (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      work_q   <= '0;
      new_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      work_q   <= work_d;
      new_q    <= new_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= push_data;
  end

endmodule
